// File: rtl/pipeline_debug_ctrl.sv
// Debug sequencer between a byte-serial host link and the 5-stage MIPS pipeline: program load, run/step, state dump.
// Define PIPELINE_DEBUG_LATCH_DUMP_EN to append the four pipeline-latch snapshots to every dump.
module pipeline_debug_ctrl #(
    parameter int          MEM_DUMP_WORDS = 8,
    parameter logic [31:0] MEM_DUMP_BASE  = 32'h0
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [7:0]   i_rx_data,
    input  logic         i_rx_valid,
    output logic [7:0]   o_tx_data,
    output logic         o_tx_valid,
    input  logic         i_tx_ready,
    output logic         o_halt,
    output logic         o_write_instruction_flag,
    output logic [31:0]  o_instruction_to_write,
    output logic [31:0]  o_address_to_write_inst,
    output logic [4:0]   o_reg_read,
    input  logic [31:0]  i_reg_content,
    output logic [31:0]  o_mem_addr,
    input  logic [31:0]  i_mem_content,
    input  logic         i_program_end,
    input  logic [63:0]  i_if_id_latch,
    input  logic [138:0] i_id_ex_latch,
    input  logic [75:0]  i_ex_mem_latch,
    input  logic [70:0]  i_mem_wb_latch,
    output logic         o_busy
);

    typedef enum logic [3:0] {
        IDLE, LD_COUNT, LD_BYTE, LD_WRITE, RUN, STEP,
        DUMP_HDR, DUMP_SET, DUMP_CAP, DUMP_SEND, ACK, NAK
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] BYTE_ACK = 8'h06;
    localparam logic [7:0] BYTE_NAK = 8'h15;
    localparam logic [7:0] HDR_END  = 8'hE0;
    localparam logic [7:0] HDR_STEP = 8'hE1;
    // Word items 0..31 are registers, the rest are data-memory words.
    localparam logic [8:0] LAST_IDX = 9'(32 + MEM_DUMP_WORDS - 1);

    state_t      state;
    logic [7:0]  single_byte;
    logic [7:0]  ld_count;
    logic [7:0]  ld_idx;
    logic [1:0]  byte_pos;
    logic [23:0] instr_sr;
    logic [8:0]  word_idx;
    logic [5:0]  byte_cnt;
    logic [31:0] word_sr;
    logic        settle;

`ifdef PIPELINE_DEBUG_LATCH_DUMP_EN
    localparam int         LATCH_BITS  = 360;
    localparam logic [5:0] LATCH_BYTES = 6'd45;
    logic [LATCH_BITS-1:0] latch_sr;
    logic [LATCH_BITS-1:0] latch_snapshot;
    logic                  latch_phase;
    // Each latch zero-extended to a whole number of bytes, IF/ID first.
    assign latch_snapshot = {i_if_id_latch, 5'd0, i_id_ex_latch, 4'd0, i_ex_mem_latch, 1'd0, i_mem_wb_latch};
`else
    logic unused_latch;
    assign unused_latch = ^{i_if_id_latch, i_id_ex_latch, i_ex_mem_latch, i_mem_wb_latch};
`endif

    assign o_busy = (state != IDLE);

    // NOTE: every register below is updated with <= so all reads in this block see pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state                    <= IDLE;
            o_halt                   <= 1'b1;
            o_write_instruction_flag <= 1'b0;
            o_instruction_to_write   <= '0;
            o_address_to_write_inst  <= '0;
            o_reg_read               <= '0;
            o_mem_addr               <= '0;
            o_tx_valid               <= 1'b0;
            o_tx_data                <= '0;
            single_byte              <= '0;
            ld_count                 <= '0;
            ld_idx                   <= '0;
            byte_pos                 <= '0;
            instr_sr                 <= '0;
            word_idx                 <= '0;
            byte_cnt                 <= '0;
            word_sr                  <= '0;
            settle                   <= 1'b0;
`ifdef PIPELINE_DEBUG_LATCH_DUMP_EN
            latch_sr                 <= '0;
            latch_phase              <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD: state <= LD_COUNT;
                        CMD_RUN, CMD_STEP: begin
                            // A finished program is never released again; dump it straight away.
                            if (i_program_end) begin
                                single_byte <= HDR_END;
                                state       <= DUMP_HDR;
                            end else begin
                                o_halt <= 1'b0;
                                state  <= (i_rx_data == CMD_RUN) ? RUN : STEP;
                            end
                        end
                        default: begin
                            single_byte <= BYTE_NAK;
                            state       <= NAK;
                        end
                    endcase
                end
                LD_COUNT: if (i_rx_valid) begin
                    ld_count <= i_rx_data;
                    ld_idx   <= '0;
                    byte_pos <= '0;
                    state    <= LD_BYTE;
                end
                LD_BYTE: if (i_rx_valid) begin
                    instr_sr <= {instr_sr[15:0], i_rx_data};
                    byte_pos <= byte_pos + 2'd1;
                    if (byte_pos == 2'd3) begin
                        o_write_instruction_flag <= 1'b1;
                        o_instruction_to_write   <= {instr_sr, i_rx_data};
                        o_address_to_write_inst  <= {22'd0, ld_idx, 2'b00};
                        state                    <= LD_WRITE;
                    end
                end
                LD_WRITE: begin
                    o_write_instruction_flag <= 1'b0;
                    // A count byte of 0 wraps to 255 here, giving 256 words.
                    if (ld_idx == ld_count - 8'd1) begin
                        single_byte <= BYTE_ACK;
                        state       <= ACK;
                    end else begin
                        ld_idx <= ld_idx + 8'd1;
                        state  <= LD_BYTE;
                    end
                end
                RUN: if (i_program_end) begin
                    o_halt      <= 1'b1;
                    single_byte <= HDR_END;
                    state       <= DUMP_HDR;
                end
                STEP: begin
                    o_halt      <= 1'b1;
                    single_byte <= HDR_STEP;
                    state       <= DUMP_HDR;
                end
                DUMP_HDR, ACK, NAK: begin
                    if (!o_tx_valid) begin
                        o_tx_valid <= 1'b1;
                        o_tx_data  <= single_byte;
`ifdef PIPELINE_DEBUG_LATCH_DUMP_EN
                        if (state == DUMP_HDR) begin
                            latch_sr    <= latch_snapshot;
                            latch_phase <= 1'b0;
                        end
`endif
                    end else if (i_tx_ready) begin
                        o_tx_valid <= 1'b0;
                        word_idx   <= '0;
                        state      <= (state == DUMP_HDR) ? DUMP_SET : IDLE;
                    end
                end
                DUMP_SET: begin
                    if (word_idx < 9'd32)
                        o_reg_read <= word_idx[4:0];
                    else
                        o_mem_addr <= MEM_DUMP_BASE + ((32'(word_idx) - 32'd32) << 2);
                    settle <= 1'b0;
                    state  <= DUMP_CAP;
                end
                DUMP_CAP: begin
                    if (!settle) begin
                        settle <= 1'b1;
                    end else begin
                        word_sr  <= (word_idx < 9'd32) ? i_reg_content : i_mem_content;
                        byte_cnt <= 6'd4;
                        state    <= DUMP_SEND;
                    end
                end
                DUMP_SEND: begin
                    if (!o_tx_valid) begin
                        o_tx_valid <= 1'b1;
`ifdef PIPELINE_DEBUG_LATCH_DUMP_EN
                        o_tx_data  <= latch_phase ? latch_sr[LATCH_BITS-1 -: 8] : word_sr[31:24];
`else
                        o_tx_data  <= word_sr[31:24];
`endif
                    end else if (i_tx_ready) begin
                        o_tx_valid <= 1'b0;
                        word_sr    <= {word_sr[23:0], 8'd0};
                        byte_cnt   <= byte_cnt - 6'd1;
`ifdef PIPELINE_DEBUG_LATCH_DUMP_EN
                        if (latch_phase)
                            latch_sr <= {latch_sr[LATCH_BITS-9:0], 8'd0};
                        if (byte_cnt == 6'd1) begin
                            if (latch_phase) begin
                                state <= IDLE;
                            end else if (word_idx == LAST_IDX) begin
                                latch_phase <= 1'b1;
                                byte_cnt    <= LATCH_BYTES;
                            end else begin
                                word_idx <= word_idx + 9'd1;
                                state    <= DUMP_SET;
                            end
                        end
`else
                        if (byte_cnt == 6'd1) begin
                            if (word_idx == LAST_IDX) begin
                                state <= IDLE;
                            end else begin
                                word_idx <= word_idx + 9'd1;
                                state    <= DUMP_SET;
                            end
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Self-checking bench for pipeline_debug_ctrl: scoreboard of expected tx bytes and write strobes,
// a small pipeline model serving register/memory reads, and directed host command sequences.
module tb_pipeline_debug_ctrl;

    localparam int          MW   = 8;
    localparam logic [31:0] BASE = 32'hFFFF_FFF8;
`ifdef PIPELINE_DEBUG_LATCH_DUMP_EN
    localparam int DUMP_BYTES = 1 + 128 + 4 * MW + 45;
`else
    localparam int DUMP_BYTES = 1 + 128 + 4 * MW;
`endif

    localparam logic [63:0]  IF_ID  = 64'h0123_4567_89AB_CDEF;
    localparam logic [138:0] ID_EX  = {11'h5AB, 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978};
    localparam logic [75:0]  EX_MEM = {12'hABC, 64'h1122_3344_5566_7788};
    localparam logic [70:0]  MEM_WB = {7'h55, 64'h99AA_BBCC_DDEE_FF00};

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         halt;
    logic         wr_flag;
    logic [31:0]  wr_instr;
    logic [31:0]  wr_addr;
    logic [4:0]   reg_read;
    logic [31:0]  reg_content;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_content;
    logic         program_end;
    logic         busy;

    always #5 clk = ~clk;

    pipeline_debug_ctrl #(.MEM_DUMP_WORDS(MW), .MEM_DUMP_BASE(BASE)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
        .o_halt(halt),
        .o_write_instruction_flag(wr_flag), .o_instruction_to_write(wr_instr),
        .o_address_to_write_inst(wr_addr),
        .o_reg_read(reg_read), .i_reg_content(reg_content),
        .o_mem_addr(mem_addr), .i_mem_content(mem_content),
        .i_program_end(program_end),
        .i_if_id_latch(IF_ID), .i_id_ex_latch(ID_EX),
        .i_ex_mem_latch(EX_MEM), .i_mem_wb_latch(MEM_WB),
        .o_busy(busy)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---- pipeline model: register file and data memory contents ----
    function automatic logic [31:0] reg_val(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (r == 5'd1) return 32'h0000_0005;
        return 32'h1357_9BDF * 32'(r);
    endfunction

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_0000;
    endfunction

    always @(posedge clk) begin
        reg_content <= reg_val(reg_read);
        mem_content <= mem_val(mem_addr);
    end

    // ---- scoreboard ----
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic [7:0] exp_q[$];
    wr_t        wr_q[$];
    logic [7:0] got_log[$];
    int         tx_count = 0;
    int         halt_low_cnt = 0;
    logic [31:0] last_wr_addr = '0;

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    endtask

    task automatic push_dump(input logic [7:0] hdr);
        logic [359:0] l;
        exp_q.push_back(hdr);
        for (int r = 0; r < 32; r++) push_word(reg_val(5'(r)));
        for (int j = 0; j < MW; j++) push_word(mem_val(BASE + 32'(j) * 32'd4));
`ifdef PIPELINE_DEBUG_LATCH_DUMP_EN
        l = {IF_ID, 5'd0, ID_EX, 4'd0, EX_MEM, 1'd0, MEM_WB};
        for (int b = 0; b < 45; b++) exp_q.push_back(l[359 - 8*b -: 8]);
`else
        l = '0;
`endif
    endtask

    logic       prev_valid = 1'b0;
    logic       prev_xfer  = 1'b0;
    logic [7:0] prev_data  = '0;

    // Single compare process: every byte handshake and every write strobe against the scoreboard.
    always @(negedge clk) begin
        logic [7:0] eb;
        wr_t        ew;
        if (prev_valid && !prev_xfer) begin
            check("tx_hold_valid", 64'(tx_valid), 64'd1);
            check("tx_hold_data", 64'(tx_data), 64'(prev_data));
        end
        if (prev_xfer) check("tx_gap_after_accept", 64'(tx_valid), 64'd0);
        if (tx_valid && tx_ready) begin
            check("tx_expected_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                eb = exp_q.pop_front();
                check("tx_byte", 64'(tx_data), 64'(eb));
            end
            got_log.push_back(tx_data);
            tx_count++;
        end
        if (wr_flag) begin
            check("strobe_expected_pending", 64'(wr_q.size() != 0), 64'd1);
            if (wr_q.size() != 0) begin
                ew = wr_q.pop_front();
                check("strobe_addr_data", {wr_addr, wr_instr}, {ew.addr, ew.data});
            end
            last_wr_addr = wr_addr;
        end
        if (!halt) halt_low_cnt++;
        prev_valid = tx_valid;
        prev_xfer  = tx_valid && tx_ready;
        prev_data  = tx_data;
    end

    // ---- stimulus helpers ----
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1 rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0 || wr_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_completes"}, 64'(n < budget), 64'd1);
        check({name, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    function automatic logic [31:0] log_word(input int at);
        return {got_log[at], got_log[at+1], got_log[at+2], got_log[at+3]};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_halt"}, 64'(halt), 64'd1);
        check({tag, "_wr_flag"}, 64'(wr_flag), 64'd0);
        check({tag, "_wr_instr"}, 64'(wr_instr), 64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check({tag, "_reg_read"}, 64'(reg_read), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
        check({tag, "_tx_data"}, 64'(tx_data), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int b0;
        int h0;
        int n;
        logic [7:0] word_bytes[8];

        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b1; program_end = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        rst = 1'b0;

        // Load two words, MSB first.
        word_bytes = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        wr_q.push_back('{addr: 32'h0, data: 32'h2001_0005});
        wr_q.push_back('{addr: 32'h4, data: 32'h0000_0000});
        exp_q.push_back(8'h06);
        send_byte(8'h4C);
        send_byte(8'h02);
        for (int i = 0; i < 8; i++) send_byte(word_bytes[i]);
        wait_idle("load2", 200);
        check("load2_last_addr", 64'(last_wr_addr), 64'h4);

        // Unknown command byte.
        exp_q.push_back(8'h15);
        send_byte(8'h7A);
        wait_idle("nak", 50);

        // Run: pipeline reports end of program during its 10th free-running cycle.
        b0 = got_log.size();
        h0 = halt_low_cnt;
        push_dump(8'hE0);
        send_byte(8'h52);
        repeat (9) @(posedge clk);
        #1 program_end = 1'b1;
        n = 0;
        while (tx_count - b0 < 20 && n < 2000) begin @(negedge clk); n++; end
        check("run_reached_stall_point", 64'(n < 2000), 64'd1);
        @(posedge clk); #1 tx_ready = 1'b0;
        repeat (50) @(posedge clk);
        #1 tx_ready = 1'b1;
        wait_idle("run_dump", 5000);
        check("run_halt_low_cycles", 64'(halt_low_cnt - h0), 64'd10);
        check("run_header", 64'(got_log[b0]), 64'hE0);
        check("run_reg1", 64'(log_word(b0 + 5)), 64'h0000_0005);
        check("run_mem_base", 64'(log_word(b0 + 129)), 64'hF0F7_0007);
        check("run_mem_wrap", 64'(log_word(b0 + 137)), 64'h0F0F_FFFF);
        check("run_byte_total", 64'(got_log.size() - b0), 64'(DUMP_BYTES));
        program_end = 1'b0;

        // Step: one free cycle; a host byte arriving mid-dump is ignored.
        b0 = got_log.size();
        h0 = halt_low_cnt;
        push_dump(8'hE1);
        send_byte(8'h53);
        send_byte(8'h4C);
        wait_idle("step_dump", 5000);
        check("step_halt_low_cycles", 64'(halt_low_cnt - h0), 64'd1);
        check("step_header", 64'(got_log[b0]), 64'hE1);
        check("step_byte_total", 64'(got_log.size() - b0), 64'(DUMP_BYTES));

        // Step after the program has ended: no release, end-of-program header.
        program_end = 1'b1;
        b0 = got_log.size();
        h0 = halt_low_cnt;
        push_dump(8'hE0);
        send_byte(8'h53);
        wait_idle("step_ended", 5000);
        check("step_ended_halt_low_cycles", 64'(halt_low_cnt - h0), 64'd0);
        check("step_ended_header", 64'(got_log[b0]), 64'hE0);
        program_end = 1'b0;

        // Reset in the middle of a load, then a fresh load restarts at address 0.
        send_byte(8'h4C);
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_reset_outputs("midload_reset");
        wr_q.push_back('{addr: 32'h0, data: 32'hDEAD_BEEF});
        exp_q.push_back(8'h06);
        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        wait_idle("reload", 200);
        check("reload_addr", 64'(last_wr_addr), 64'h0);

        // Count byte 0 loads 256 words.
        for (int k = 0; k < 256; k++)
            wr_q.push_back('{addr: 32'(k) * 32'd4, data: {8'(k), 8'h11, ~8'(k), 8'h77}});
        exp_q.push_back(8'h06);
        send_byte(8'h4C);
        send_byte(8'h00);
        for (int k = 0; k < 256; k++) begin
            send_byte(8'(k)); send_byte(8'h11); send_byte(~8'(k)); send_byte(8'h77);
        end
        wait_idle("load256", 200);
        check("load256_last_addr", 64'(last_wr_addr), 64'h3FC);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
